// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine spin controller.
// Holds the FSM state enum, reel width, payout table and credit ceiling.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN_ALL,
        SPIN_23,
        SPIN_3,
        EVAL
    } state_t;

    localparam int REEL_W     = 3;
    localparam int CNT_W      = 16;
    localparam int PAY_TRIPLE = 10;
    localparam int PAY_PAIR   = 2;
    localparam int CREDIT_MAX = 255;

    function automatic logic [7:0] payout_of(
        input logic [REEL_W-1:0] a,
        input logic [REEL_W-1:0] b,
        input logic [REEL_W-1:0] c
    );
        logic [7:0] p;
        p = 8'd0;
        if (a == b && b == c) begin
            p = PAY_TRIPLE[7:0];
        end else if (a == b || b == c || a == c) begin
            p = PAY_PAIR[7:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/reel_stepper.sv
// One reel: a 3-bit symbol that advances by a fixed increment when enabled.
// Wraps modulo 8 naturally through the 3-bit adder.
module reel_stepper
    import slot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [REEL_W-1:0] inc,
    output logic [REEL_W-1:0] sym
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sym <= '0;
        end else if (en) begin
            sym <= sym + inc;
        end
    end

endmodule

// File: rtl/spin_controller.sv
// Slot-machine round controller: accepts a spin, animates three staggered
// reels on tick, then pays out into a saturating credit balance.
module spin_controller
    import slot_pkg::*;
#(
    parameter int SPIN_TICKS    = 20,
    parameter int STAGGER_TICKS = 10,
    parameter int INIT_CREDITS  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spin,
    input  logic              tick,
    output logic [REEL_W-1:0] reel0,
    output logic [REEL_W-1:0] reel1,
    output logic [REEL_W-1:0] reel2,
    output logic [7:0]        credits,
    output logic              busy,
    output logic              win,
    output logic [7:0]        payout
);

    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_TICKS - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             spin_q;
    logic             accept;
    logic             en0;
    logic             en1;
    logic             en2;
    logic [7:0]       pay;
    logic [8:0]       sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        en0     = 1'b0;
        en1     = 1'b0;
        en2     = 1'b0;
        unique case (state)
            IDLE: begin
                if (spin && !spin_q && credits != 8'd0) begin
                    accept  = 1'b1;
                    state_n = SPIN_ALL;
                    cnt_n   = '0;
                end
            end
            SPIN_ALL: begin
                if (tick) begin
                    en0 = 1'b1;
                    en1 = 1'b1;
                    en2 = 1'b1;
                    if (cnt == SPIN_LAST) begin
                        state_n = SPIN_23;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            SPIN_23: begin
                if (tick) begin
                    en1 = 1'b1;
                    en2 = 1'b1;
                    if (cnt == STAG_LAST) begin
                        state_n = SPIN_3;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            SPIN_3: begin
                if (tick) begin
                    en2 = 1'b1;
                    if (cnt == STAG_LAST) begin
                        state_n = EVAL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            EVAL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign pay  = payout_of(reel0, reel1, reel2);
    assign sum  = {1'b0, credits} + {1'b0, pay};
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            spin_q  <= spin;
            credits <= 8'(INIT_CREDITS);
            payout  <= 8'd0;
            win     <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            spin_q <= spin;
            win    <= 1'b0;
            if (accept) begin
                credits <= credits - 8'd1;
                payout  <= 8'd0;
            end
            // Carry out of the 9-bit sum means the balance passed 255.
            if (state == EVAL) begin
                payout  <= pay;
                win     <= (pay != 8'd0);
                credits <= sum[8] ? CREDIT_MAX[7:0] : sum[7:0];
            end
        end
    end

    reel_stepper u_reel0 (
        .clk (clk),
        .rst (rst),
        .en  (en0),
        .inc (3'd1),
        .sym (reel0)
    );

    reel_stepper u_reel1 (
        .clk (clk),
        .rst (rst),
        .en  (en1),
        .inc (3'd3),
        .sym (reel1)
    );

    reel_stepper u_reel2 (
        .clk (clk),
        .rst (rst),
        .en  (en2),
        .inc (3'd5),
        .sym (reel2)
    );

endmodule

// File: tb/tb_spin_controller.sv
// Directed bench for spin_controller: four parameterisations share one
// stimulus stream; each is checked against hand-computed reel/credit values.
module tb_spin_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spin = 1'b0;
    logic tick = 1'b0;

    logic [2:0] a_r0, a_r1, a_r2, b_r0, b_r1, b_r2;
    logic [2:0] c_r0, c_r1, c_r2, d_r0, d_r1, d_r2;
    logic [7:0] a_cr, b_cr, c_cr, d_cr, a_pay, b_pay, c_pay, d_pay;
    logic a_busy, b_busy, c_busy, d_busy, a_win, b_win, c_win, d_win;

    int n_checks = 0;
    int n_fail = 0;
    int a_wins = 0;
    int b_wins = 0;
    int c_busy_cyc = 0;
    int tcnt = 0;

    always #5 clk = ~clk;

    spin_controller dut_a (
        .clk(clk), .rst(rst), .spin(spin), .tick(tick),
        .reel0(a_r0), .reel1(a_r1), .reel2(a_r2), .credits(a_cr),
        .busy(a_busy), .win(a_win), .payout(a_pay)
    );

    spin_controller #(.SPIN_TICKS(8), .STAGGER_TICKS(8)) dut_b (
        .clk(clk), .rst(rst), .spin(spin), .tick(tick),
        .reel0(b_r0), .reel1(b_r1), .reel2(b_r2), .credits(b_cr),
        .busy(b_busy), .win(b_win), .payout(b_pay)
    );

    spin_controller #(.INIT_CREDITS(0)) dut_c (
        .clk(clk), .rst(rst), .spin(spin), .tick(tick),
        .reel0(c_r0), .reel1(c_r1), .reel2(c_r2), .credits(c_cr),
        .busy(c_busy), .win(c_win), .payout(c_pay)
    );

    spin_controller #(
        .SPIN_TICKS(8), .STAGGER_TICKS(8), .INIT_CREDITS(250)
    ) dut_d (
        .clk(clk), .rst(rst), .spin(spin), .tick(tick),
        .reel0(d_r0), .reel1(d_r1), .reel2(d_r2), .credits(d_cr),
        .busy(d_busy), .win(d_win), .payout(d_pay)
    );

    always @(posedge clk) begin
        if (a_win) a_wins <= a_wins + 1;
        if (b_win) b_wins <= b_wins + 1;
        if (c_busy) c_busy_cyc <= c_busy_cyc + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (a_busy !== 1'b0 && k < 2000) begin
            cyc(1);
            k++;
        end
        check(tag, int'(k < 2000), 1);
        cyc(2);
    endtask

    task automatic pulse_spin();
        spin = 1'b1;
        cyc(2);
        spin = 1'b0;
    endtask

    task automatic check_a(input string tag, input int r0, input int r1,
                           input int r2, input int pay, input int cr);
        check({tag, "_r0"}, a_r0, r0);
        check({tag, "_r1"}, a_r1, r1);
        check({tag, "_r2"}, a_r2, r2);
        check({tag, "_pay"}, a_pay, pay);
        check({tag, "_cr"}, a_cr, cr);
        check({tag, "_busy"}, a_busy, 0);
    endtask

    initial begin
        cyc(3);
        check_a("rst", 0, 0, 0, 0, 10);
        check("rst_win", a_win, 0);
        check("rst_c_cr", c_cr, 0);
        check("rst_d_cr", d_cr, 250);
        rst = 1'b0;
        cyc(2);

        // Round 1: 20/30/40 steps of +1/+3/+5 -> 4,2,0
        pulse_spin();
        check("r1_busy", a_busy, 1);
        check("r1_c_idle", c_busy, 0);
        wait_idle("r1_timeout");
        check_a("r1", 4, 2, 0, 0, 9);
        check("r1_wins", a_wins, 0);
        check("r1_b_r0", b_r0, 0);
        check("r1_b_r1", b_r1, 0);
        check("r1_b_r2", b_r2, 0);
        check("r1_b_pay", b_pay, 10);
        check("r1_b_cr", b_cr, 19);
        check("r1_b_wins", b_wins, 1);
        check("r1_d_sat", d_cr, 255);
        check("r1_c_cr", c_cr, 0);

        // Round 2: 4,2,0 + 4,2,0 -> 0,4,0 pair
        pulse_spin();
        wait_idle("r2_timeout");
        check_a("r2", 0, 4, 0, 2, 10);
        check("r2_wins", a_wins, 1);
        check("r2_b_cr", b_cr, 28);
        check("r2_d_sat", d_cr, 255);

        // Held spin plus an extra edge mid-round -> single round, 4,6,0
        spin = 1'b1;
        cyc(20);
        spin = 1'b0;
        cyc(5);
        spin = 1'b1;
        cyc(1);
        check("hold_busy", a_busy, 1);
        wait_idle("hold_timeout");
        cyc(30);
        check_a("hold", 4, 6, 0, 0, 9);
        check("hold_wins", a_wins, 1);
        spin = 1'b0;
        cyc(2);

        // Reset in SPIN_23 with spin held through reset
        pulse_spin();
        cyc(100);
        check("mid_busy", a_busy, 1);
        check("mid_r0_stopped", a_r0, 0);
        rst = 1'b1;
        spin = 1'b1;
        cyc(1);
        check_a("mid_rst", 0, 0, 0, 0, 10);
        rst = 1'b0;
        cyc(10);
        check("held_no_trig", a_busy, 0);
        spin = 1'b0;
        cyc(2);
        pulse_spin();
        check("post_busy", a_busy, 1);
        wait_idle("post_timeout");
        check_a("post", 4, 2, 0, 0, 9);

        check("c_never_busy", c_busy_cyc, 0);
        check("c_cr_end", c_cr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
